// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce scheduler.
//   ceillog2 : smallest w with 2**w >= v
//   chw_of   : channel index width, never below 1
//   cw_of    : shared hold-counter width
//   state_t  : scheduler state encoding
package debounce_pkg;

    function automatic int unsigned ceillog2(input int unsigned v);
        int unsigned w;
        w = 0;
        while ((64'(1) << w) < 64'(v)) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int unsigned chw_of(input int unsigned n_ch);
        return (ceillog2(n_ch) < 1) ? 1 : ceillog2(n_ch);
    endfunction

    function automatic int unsigned cw_of(input int unsigned n_max);
        return (ceillog2(n_max) < 1) ? 1 : ceillog2(n_max);
    endfunction

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        COUNT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_bank.sv
// Per-bit flop chain bringing raw asynchronous inputs into the clk domain.
//   clk      : system clock
//   rst_a_p  : async active-high reset, clears every stage
//   d        : raw inputs
//   q        : synchronised inputs (last stage)
module sync_bank #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_a_p,
    input  logic [N_CH-1:0] d,
    output logic [N_CH-1:0] q
);

    logic [N_CH-1:0] stg [SYNC_STAGES];

    // Shift chain
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces N_CH inputs with a single shared hold counter granted round-robin
// to whichever channel currently disagrees with its debounced level.
//   clk        : system clock
//   rst_a_p    : async active-high reset
//   btn_raw    : raw asynchronous inputs
//   btn_stable : debounced levels
//   btn_rise   : one-cycle pulse on a 0->1 debounced change
//   btn_fall   : one-cycle pulse on a 1->0 debounced change
//   busy       : counter is granted to a channel
//   active_ch  : channel holding (or last holding) the counter
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned N_MAX       = 5000,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CHW        = chw_of(N_CH)
) (
    input  logic            clk,
    input  logic            rst_a_p,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_stable,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic            busy,
    output logic [CHW-1:0]  active_ch
);

    localparam int unsigned CW = cw_of(N_MAX);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [CHW-1:0]  rr_ptr, rr_nxt;
    logic [CHW-1:0]  ach_nxt;
    logic [N_CH-1:0] stable_nxt, rise_nxt, fall_nxt;
    logic            busy_nxt;

    logic [N_CH-1:0] btn_s;
    logic [N_CH-1:0] diff;
    logic            found;
    logic [CHW-1:0]  pick;
    logic [31:0]     pick_idx;
    logic [CHW-1:0]  next_ptr;

    sync_bank #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_a_p (rst_a_p),
        .d       (btn_raw),
        .q       (btn_s)
    );

    assign diff = btn_s ^ btn_stable;

    // Pointer to the channel after the one just serviced or aborted
    assign next_ptr = (active_ch == CHW'(N_CH - 1)) ? '0 : active_ch + CHW'(1);

    // Round-robin search of diff starting at rr_ptr; first set bit wins
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_idx = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            pick_idx = 32'(rr_ptr) + i;
            if (pick_idx >= N_CH) begin
                pick_idx = pick_idx - N_CH;
            end
            if (!found && diff[CHW'(pick_idx)]) begin
                found = 1'b1;
                pick  = CHW'(pick_idx);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state      <= SCAN;
            cnt        <= '0;
            rr_ptr     <= '0;
            active_ch  <= '0;
            btn_stable <= '0;
            btn_rise   <= '0;
            btn_fall   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rr_ptr     <= rr_nxt;
            active_ch  <= ach_nxt;
            btn_stable <= stable_nxt;
            btn_rise   <= rise_nxt;
            btn_fall   <= fall_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rr_nxt     = rr_ptr;
        ach_nxt    = active_ch;
        stable_nxt = btn_stable;
        rise_nxt   = '0;
        fall_nxt   = '0;

        case (state)
            SCAN: begin
                if (found) begin
                    ach_nxt   = pick;
                    cnt_nxt   = '0;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                // Input fell back to the accepted level: release the counter
                if (btn_s[active_ch] == btn_stable[active_ch]) begin
                    cnt_nxt   = '0;
                    rr_nxt    = next_ptr;
                    state_nxt = SCAN;
                end else if (cnt == CW'(N_MAX - 1)) begin
                    state_nxt = COMMIT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            COMMIT: begin
                stable_nxt[active_ch] = ~btn_stable[active_ch];
                rise_nxt[active_ch]   = ~btn_stable[active_ch];
                fall_nxt[active_ch]   = btn_stable[active_ch];
                rr_nxt                = next_ptr;
                state_nxt             = SCAN;
            end
            default: begin
                state_nxt = SCAN;
            end
        endcase

        busy_nxt = (state_nxt != SCAN);
    end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N_CH=4, N_MAX=8, SYNC_STAGES=2.
// Expected pulses are queued with their due cycle when stimulus is applied and
// matched against every observed pulse.
module tb_debounce_scheduler;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned N_MAX       = 8;
    localparam int unsigned SYNC_STAGES = 2;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    logic       clk;
    logic       rst_a_p;
    logic [3:0] btn_raw;
    logic [3:0] btn_stable;
    logic [3:0] btn_rise;
    logic [3:0] btn_fall;
    logic       busy;
    logic [1:0] active_ch;

    int   cyc;
    int   c0;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    debounce_scheduler #(
        .N_CH        (N_CH),
        .N_MAX       (N_MAX),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_a_p    (rst_a_p),
        .btn_raw    (btn_raw),
        .btn_stable (btn_stable),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .busy       (busy),
        .active_ch  (active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Advance one cycle, sample on the falling edge and score any pulses
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("pulse_missing_cycle", 32'(cyc), 32'(e.cyc));
        end
        if ((btn_rise | btn_fall) != 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {24'b0, btn_rise, btn_fall}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("pulse_rise", 32'(btn_rise), 32'(e.rise));
                chk("pulse_fall", 32'(btn_fall), 32'(e.fall));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stable"}, 32'(btn_stable), 32'd0);
        chk({tag, "_rise"},   32'(btn_rise),   32'd0);
        chk({tag, "_fall"},   32'(btn_fall),   32'd0);
        chk({tag, "_busy"},   32'(busy),       32'd0);
        chk({tag, "_active"}, 32'(active_ch),  32'd0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        cyc     = 0;
        rst_a_p = 1'b1;
        btn_raw = 4'b0000;

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        rst_a_p = 1'b0;
        repeat (4) tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_stable", 32'(btn_stable), 32'd0);

        // Clean press on channel 1
        c0 = cyc;
        btn_raw = 4'b0010;
        exp_q.push_back('{c0 + 12, 4'b0010, 4'b0000});
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("press_busy", 32'(busy), 32'(k >= 3 && k <= 11));
            if (k == 3)  chk("press_active", 32'(active_ch), 32'd1);
            if (k == 11) chk("press_stable_pre", 32'(btn_stable), 32'd0);
        end
        chk("press_stable", 32'(btn_stable), 32'b0010);

        // Release of channel 1
        c0 = cyc;
        btn_raw = 4'b0000;
        exp_q.push_back('{c0 + 12, 4'b0000, 4'b0010});
        repeat (14) tick();
        chk("release_stable", 32'(btn_stable), 32'd0);

        // Bounce on channel 1: high for five cycles only
        c0 = cyc;
        btn_raw = 4'b0010;
        repeat (4) tick();
        chk("bounce_active", 32'(active_ch), 32'd1);
        chk("bounce_busy_mid", 32'(busy), 32'd1);
        tick();
        btn_raw = 4'b0000;
        for (int k = 6; k <= 17; k++) begin
            tick();
            chk("bounce_busy", 32'(busy), 32'(k <= 7));
        end
        chk("bounce_stable", 32'(btn_stable), 32'd0);

        // Round-robin: pointer sits at 2, so channel 2 is served before 0
        c0 = cyc;
        btn_raw = 4'b0101;
        exp_q.push_back('{c0 + 12, 4'b0100, 4'b0000});
        exp_q.push_back('{c0 + 22, 4'b0001, 4'b0000});
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 3)  chk("rr_first_active", 32'(active_ch), 32'd2);
            if (k == 13) chk("rr_second_active", 32'(active_ch), 32'd0);
        end
        chk("rr_stable", 32'(btn_stable), 32'b0101);

        // Both released: pointer at 1, so channel 2 again precedes 0
        c0 = cyc;
        btn_raw = 4'b0000;
        exp_q.push_back('{c0 + 12, 4'b0000, 4'b0100});
        exp_q.push_back('{c0 + 22, 4'b0000, 4'b0001});
        repeat (24) tick();
        chk("rr_release_stable", 32'(btn_stable), 32'd0);

        // Inputs high through reset are debounced after release
        btn_raw = 4'b0101;
        rst_a_p = 1'b1;
        #1;
        chk_all_zero("preload_rst");
        repeat (3) tick();
        chk_all_zero("preload_hold");
        c0 = cyc;
        rst_a_p = 1'b0;
        exp_q.push_back('{c0 + 12, 4'b0001, 4'b0000});
        exp_q.push_back('{c0 + 22, 4'b0100, 4'b0000});
        repeat (24) tick();
        chk("preload_stable", 32'(btn_stable), 32'b0101);

        // Async reset while channel 3 is counting (cnt = 4)
        c0 = cyc;
        btn_raw = 4'b1101;
        repeat (7) tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        chk("abort_active_pre", 32'(active_ch), 32'd3);
        rst_a_p = 1'b1;
        #1;
        chk_all_zero("abort_rst");
        btn_raw = 4'b0000;
        repeat (3) tick();
        rst_a_p = 1'b0;
        repeat (20) tick();
        chk("abort_busy_post", 32'(busy), 32'd0);
        chk("abort_stable_post", 32'(btn_stable), 32'd0);

        chk("pending_pulses", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
